datapath_sequencer: RTL and testbench
=====================================

# datapath_sequencer

Moore-style controller that sequences the lab datapath: register file, A/B operand registers, shifter, ALU, C output register and status register. It accepts one 16-bit instruction through a start/done handshake. It then drives the datapath control lines (readnum, writenum, write, loada, loadb, loadc, loads, asel, vsel, shift, ALUop, datapath_in) over several cycles, replacing manual switch-driven sequencing. It sits between the top-level instruction source (switches or a future instruction register) and the existing datapath.

## Interface
- No parameters; datapath widths fixed (16-bit data, 8 registers).
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- instr  input  16  [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm, [7:0] imm8
- busy  output  1  high while an instruction is in flight
- done  output  1  one-cycle pulse on completion
- illegal  output  1  one-cycle pulse instead of done for an unsupported encoding
- readnum, writenum  output  3  register file ports
- write, loada, loadb, loadc, loads  output  1  load enables
- asel, vsel  output  1  asel=1 selects zero for A; vsel=1 selects datapath_in for write-back
- shift  output  2  shifter control
- ALUop  output  2  00 add, 01 sub, 10 and, 11 not-B
- datapath_in  output  16  sign-extended imm8

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, WRITE_REG, WRITE_IMM, DONE.
- IDLE → next state when start=1. instr is latched into an internal register on that edge. Later changes to instr are ignored.
- Decoding, by opcode/op:
  - MOVI (110/10): WRITE_IMM → DONE. Drive writenum=Rn, vsel=1, write=1, datapath_in=sext(imm8).
  - MOV (110/00): LOAD_B → EXEC → WRITE_REG → DONE. EXEC drives asel=1, ALUop=00, shift=instr.shift.
  - ADD (101/00) and AND (101/10): LOAD_A → LOAD_B → EXEC → WRITE_REG → DONE.
  - CMP (101/01): LOAD_A → LOAD_B → EXEC → DONE. EXEC drives loads=1, ALUop=01, loadc=0.
  - MVN (101/11): LOAD_B → EXEC → WRITE_REG → DONE. EXEC drives ALUop=11.
  - Any other encoding: IDLE → DONE with illegal=1 and done=0. No load or write asserted.
- Per-state outputs:
  - LOAD_A: readnum=Rn, loada=1.
  - LOAD_B: readnum=Rm, loadb=1.
  - EXEC: loadc=1 except CMP; shift applied.
  - WRITE_REG: writenum=Rd, vsel=0, write=1.
- DONE → IDLE unconditionally.
- All outputs are a function of the state register and the latched instruction only (Moore). Every control line not listed for a state is 0.

## Timing
- Reset (asynchronous, any state, including mid-instruction):
  - state=IDLE, latched instr=0.
  - All outputs 0, including busy, done, illegal and datapath_in.
- busy is high in every state except IDLE.
- Latency, counted from the start edge to the done pulse (inclusive of DONE):
  - MOVI: 2 cycles.
  - MOV and MVN: 4 cycles.
  - CMP: 4 cycles.
  - ADD and AND: 5 cycles.
  - Illegal: 1 cycle.
- start asserted while busy is ignored and not queued.
- Back-to-back operation: start held high through DONE is accepted on the first IDLE edge. Minimum gap between instructions is one IDLE cycle.
- write is high for exactly one cycle per instruction, except CMP and illegal encodings, where it is never high.

## Configuration
- DPCTRL_CMP_EN defined: CMP is decoded and drives loads as above.
- DPCTRL_CMP_EN undefined:
  - 101/01 is an illegal encoding.
  - loads is tied to 0.
  - No status-related logic is compiled.

## Structure
- Package dp_seq_pkg holds:
  - state enum;
  - opcode/op constants (OPC_MOV=110, OPC_ALU=101);
  - ALUop constants;
  - instruction field bit positions.
- Sub-module dp_instr_decode: combinational. Maps the latched instr to the first state, the has_write flag and the illegal flag. The FSM and output decode stay in datapath_sequencer.

## Test plan
- Reset, then MOVI R0,#7 (instr=16'hD007) with start=1 → WRITE_IMM next cycle: writenum=0, vsel=1, write=1, datapath_in=16'h0007. done pulses one cycle later.
- MOVI R1,#-2 (imm8=8'hFE) → datapath_in=16'hFFFE.
- ADD R2,R1,R0 LSL#1 (Rn=1, Rd=2, shift=01, Rm=0):
  - loada with readnum=1, then loadb with readnum=0;
  - EXEC with shift=01, ALUop=00, loadc=1;
  - write with writenum=2; done 5 cycles after start.
- CMP R0,R1 → loads=1 for one cycle, write never asserted, done at cycle 4. Without DPCTRL_CMP_EN → illegal pulse at cycle 1, no loads.
- start re-pulsed during an ADD with a different instr → ignored. The original sequence completes unchanged.
- reset_n dropped during EXEC of MVN → all outputs 0 immediately. After release the FSM is in IDLE, with no write issued.

Source files
------------

// File: rtl/dp_seq_pkg.sv
// Shared types and encodings for the datapath sequencer.
// CMP decode is compiled only when DPCTRL_CMP_EN is defined.
package dp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_A    = 3'd1,
    S_LOAD_B    = 3'd2,
    S_EXEC      = 3'd3,
    S_WRITE_REG = 3'd4,
    S_WRITE_IMM = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;
  localparam int IMM_LSB = 0;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/dp_instr_decode.sv
// Combinational instruction classifier: first FSM state and per-instruction flags.
// CMP (101/01) is recognised only when DPCTRL_CMP_EN is defined.
module dp_instr_decode
  import dp_seq_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output state_t     first_state,
  output logic       has_write,
  output logic       illegal,
  output logic       is_cmp,
  output logic       is_mov,
  output logic [1:0] alu_op
);

  always_comb begin
    first_state = S_DONE;
    has_write   = 1'b0;
    illegal     = 1'b1;
    is_cmp      = 1'b0;
    is_mov      = 1'b0;
    alu_op      = ALU_ADD;
    if (opcode == OPC_MOV) begin
      case (op)
        OP_MOVI: begin
          first_state = S_WRITE_IMM;
          has_write   = 1'b1;
          illegal     = 1'b0;
        end
        OP_MOV: begin
          first_state = S_LOAD_B;
          has_write   = 1'b1;
          illegal     = 1'b0;
          is_mov      = 1'b1;
        end
        default: ;
      endcase
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD: begin
          first_state = S_LOAD_A;
          has_write   = 1'b1;
          illegal     = 1'b0;
        end
        OP_AND: begin
          first_state = S_LOAD_A;
          has_write   = 1'b1;
          illegal     = 1'b0;
          alu_op      = ALU_AND;
        end
        OP_MVN: begin
          first_state = S_LOAD_B;
          has_write   = 1'b1;
          illegal     = 1'b0;
          alu_op      = ALU_NOTB;
        end
`ifdef DPCTRL_CMP_EN
        OP_CMP: begin
          first_state = S_LOAD_A;
          illegal     = 1'b0;
          is_cmp      = 1'b1;
          alu_op      = ALU_SUB;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Moore sequencer driving the lab datapath from one latched 16-bit instruction.
// Define DPCTRL_CMP_EN to decode CMP and drive loads; otherwise loads is tied low.
module datapath_sequencer
  import dp_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] instr,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] datapath_in
);

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;

  logic        busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;
  logic [2:0]  readnum_q, readnum_d, writenum_q, writenum_d;
  logic        write_q, write_d, loada_q, loada_d, loadb_q, loadb_d;
  logic        loadc_q, loadc_d, asel_q, asel_d, vsel_q, vsel_d;
  logic [1:0]  shift_q, shift_d, aluop_q, aluop_d;
  logic [15:0] dpin_q, dpin_d;
`ifdef DPCTRL_CMP_EN
  logic        loads_q, loads_d;
`endif

  state_t     dec_first;
  logic       dec_has_write, dec_illegal, dec_is_cmp, dec_is_mov;
  logic [1:0] dec_alu_op;

  // The decoder looks at the instruction that will be held after this edge,
  // so the first state can be chosen on the accepting edge itself.
  always_comb begin
    instr_d = instr_q;
    if (state_q == S_IDLE && start) instr_d = instr;
  end

  dp_instr_decode u_decode (
    .opcode      (instr_d[OPC_LSB +: 3]),
    .op          (instr_d[OP_LSB +: 2]),
    .first_state (dec_first),
    .has_write   (dec_has_write),
    .illegal     (dec_illegal),
    .is_cmp      (dec_is_cmp),
    .is_mov      (dec_is_mov),
    .alu_op      (dec_alu_op)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = dec_first;
      S_LOAD_A:    state_d = S_LOAD_B;
      S_LOAD_B:    state_d = S_EXEC;
      S_EXEC:      state_d = dec_has_write ? S_WRITE_REG : S_DONE;
      S_WRITE_REG: state_d = S_DONE;
      S_WRITE_IMM: state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state register.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    readnum_d  = 3'd0;
    writenum_d = 3'd0;
    write_d    = 1'b0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    asel_d     = 1'b0;
    vsel_d     = 1'b0;
    shift_d    = 2'b00;
    aluop_d    = 2'b00;
    dpin_d     = 16'h0000;
`ifdef DPCTRL_CMP_EN
    loads_d    = 1'b0;
`endif
    case (state_d)
      S_LOAD_A: begin
        readnum_d = instr_d[RN_LSB +: 3];
        loada_d   = 1'b1;
      end
      S_LOAD_B: begin
        readnum_d = instr_d[RM_LSB +: 3];
        loadb_d   = 1'b1;
      end
      S_EXEC: begin
        loadc_d = ~dec_is_cmp;
        asel_d  = dec_is_mov;
        shift_d = instr_d[SH_LSB +: 2];
        aluop_d = dec_alu_op;
`ifdef DPCTRL_CMP_EN
        loads_d = dec_is_cmp;
`endif
      end
      S_WRITE_REG: begin
        writenum_d = instr_d[RD_LSB +: 3];
        write_d    = 1'b1;
      end
      S_WRITE_IMM: begin
        writenum_d = instr_d[RN_LSB +: 3];
        vsel_d     = 1'b1;
        write_d    = 1'b1;
        dpin_d     = sext8(instr_d[IMM_LSB +: 8]);
      end
      S_DONE: begin
        done_d    = ~dec_illegal;
        illegal_d = dec_illegal;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      instr_q    <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      readnum_q  <= 3'd0;
      writenum_q <= 3'd0;
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      asel_q     <= 1'b0;
      vsel_q     <= 1'b0;
      shift_q    <= 2'b00;
      aluop_q    <= 2'b00;
      dpin_q     <= 16'h0000;
`ifdef DPCTRL_CMP_EN
      loads_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      readnum_q  <= readnum_d;
      writenum_q <= writenum_d;
      write_q    <= write_d;
      loada_q    <= loada_d;
      loadb_q    <= loadb_d;
      loadc_q    <= loadc_d;
      asel_q     <= asel_d;
      vsel_q     <= vsel_d;
      shift_q    <= shift_d;
      aluop_q    <= aluop_d;
      dpin_q     <= dpin_d;
`ifdef DPCTRL_CMP_EN
      loads_q    <= loads_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign readnum     = readnum_q;
  assign writenum    = writenum_q;
  assign write       = write_q;
  assign loada       = loada_q;
  assign loadb       = loadb_q;
  assign loadc       = loadc_q;
  assign asel        = asel_q;
  assign vsel        = vsel_q;
  assign shift       = shift_q;
  assign ALUop       = aluop_q;
  assign datapath_in = dpin_q;
`ifdef DPCTRL_CMP_EN
  assign loads       = loads_q;
`else
  assign loads       = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer; checks the full output vector every cycle.
// CMP expectations follow DPCTRL_CMP_EN as defined for the build.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] instr;
  logic        busy, done, illegal, write, loada, loadb, loadc, loads, asel, vsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;

  int n_cmp = 0;
  int n_err = 0;

  datapath_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .instr       (instr),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .readnum     (readnum),
    .writenum    (writenum),
    .write       (write),
    .loada       (loada),
    .loadb       (loadb),
    .loadc       (loadc),
    .loads       (loads),
    .asel        (asel),
    .vsel        (vsel),
    .shift       (shift),
    .ALUop       (ALUop),
    .datapath_in (datapath_in)
  );

  always #5 clk = ~clk;

  logic [35:0] obs;
  assign obs = {busy, done, illegal, readnum, writenum, write, loada, loadb,
                loadc, loads, asel, vsel, shift, ALUop, datapath_in};

  function automatic logic [35:0] mk(
    input logic b, input logic d, input logic il,
    input logic [2:0] rn, input logic [2:0] wn,
    input logic w, input logic la, input logic lb, input logic lc,
    input logic ls, input logic as, input logic vs,
    input logic [1:0] sh, input logic [1:0] alu, input logic [15:0] dp);
    return {b, d, il, rn, wn, w, la, lb, lc, ls, as, vs, sh, alu, dp};
  endfunction

  localparam logic [35:0] ZERO = 36'h0;

  task automatic chk(input string tag, input logic [35:0] e);
    n_cmp++;
    assert (obs === e)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    instr   = 16'h0000;
    #3;
    chk("reset_async", ZERO);
    repeat (2) tick();
    chk("reset_held", ZERO);
    reset_n = 1'b1;
    tick();
    chk("idle_after_reset", ZERO);

    // MOVI R0,#7; instr changed after acceptance must not matter
    instr = 16'hD007; start = 1'b1;
    tick();
    start = 1'b0; instr = 16'hFFFF;
    chk("movi0_wimm", mk(1,0,0, 3'd0,3'd0, 1,0,0,0,0,0,1, 2'b00,2'b00, 16'h0007));
    tick();
    chk("movi0_done", mk(1,1,0, 3'd0,3'd0, 0,0,0,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("movi0_idle", ZERO);

    // MOVI R1,#-2
    instr = 16'hD1FE; start = 1'b1;
    tick();
    start = 1'b0;
    chk("movi1_wimm", mk(1,0,0, 3'd0,3'd1, 1,0,0,0,0,0,1, 2'b00,2'b00, 16'hFFFE));
    tick();
    chk("movi1_done", mk(1,1,0, 3'd0,3'd0, 0,0,0,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("movi1_idle", ZERO);

    // ADD R2,R1,R0 LSL#1 with an ignored start pulse, then a back-to-back MOVI R3,#-1
    instr = 16'hA148; start = 1'b1;
    tick();
    chk("add_loada", mk(1,0,0, 3'd1,3'd0, 0,1,0,0,0,0,0, 2'b00,2'b00, 16'h0000));
    instr = 16'hD3FF; start = 1'b1;
    tick();
    start = 1'b0;
    chk("add_loadb", mk(1,0,0, 3'd0,3'd0, 0,0,1,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("add_exec", mk(1,0,0, 3'd0,3'd0, 0,0,0,1,0,0,0, 2'b01,2'b00, 16'h0000));
    tick();
    chk("add_wreg", mk(1,0,0, 3'd0,3'd2, 1,0,0,0,0,0,0, 2'b00,2'b00, 16'h0000));
    start = 1'b1;
    tick();
    chk("add_done", mk(1,1,0, 3'd0,3'd0, 0,0,0,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("b2b_idle_gap", ZERO);
    tick();
    start = 1'b0;
    chk("b2b_movi3_wimm", mk(1,0,0, 3'd0,3'd3, 1,0,0,0,0,0,1, 2'b00,2'b00, 16'hFFFF));
    tick();
    chk("b2b_movi3_done", mk(1,1,0, 3'd0,3'd0, 0,0,0,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("b2b_idle", ZERO);

    // CMP R0,R1
    instr = 16'hA801; start = 1'b1;
    tick();
    start = 1'b0;
`ifdef DPCTRL_CMP_EN
    chk("cmp_loada", mk(1,0,0, 3'd0,3'd0, 0,1,0,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("cmp_loadb", mk(1,0,0, 3'd1,3'd0, 0,0,1,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("cmp_exec", mk(1,0,0, 3'd0,3'd0, 0,0,0,0,1,0,0, 2'b00,2'b01, 16'h0000));
    tick();
    chk("cmp_done", mk(1,1,0, 3'd0,3'd0, 0,0,0,0,0,0,0, 2'b00,2'b00, 16'h0000));
`else
    chk("cmp_illegal", mk(1,0,1, 3'd0,3'd0, 0,0,0,0,0,0,0, 2'b00,2'b00, 16'h0000));
`endif
    tick();
    chk("cmp_idle", ZERO);

    // MOV R4,R2 shift=10
    instr = 16'hC092; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mov_loadb", mk(1,0,0, 3'd2,3'd0, 0,0,1,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("mov_exec", mk(1,0,0, 3'd0,3'd0, 0,0,0,1,0,1,0, 2'b10,2'b00, 16'h0000));
    tick();
    chk("mov_wreg", mk(1,0,0, 3'd0,3'd4, 1,0,0,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("mov_done", mk(1,1,0, 3'd0,3'd0, 0,0,0,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("mov_idle", ZERO);

    // AND R5,R6,R7
    instr = 16'hB6A7; start = 1'b1;
    tick();
    start = 1'b0;
    chk("and_loada", mk(1,0,0, 3'd6,3'd0, 0,1,0,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("and_loadb", mk(1,0,0, 3'd7,3'd0, 0,0,1,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("and_exec", mk(1,0,0, 3'd0,3'd0, 0,0,0,1,0,0,0, 2'b00,2'b10, 16'h0000));
    tick();
    chk("and_wreg", mk(1,0,0, 3'd0,3'd5, 1,0,0,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("and_done", mk(1,1,0, 3'd0,3'd0, 0,0,0,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("and_idle", ZERO);

    // Unsupported opcode 111
    instr = 16'hE000; start = 1'b1;
    tick();
    start = 1'b0;
    chk("illegal_done", mk(1,0,1, 3'd0,3'd0, 0,0,0,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("illegal_idle", ZERO);

    // MVN R3,R1 aborted by reset during EXEC
    instr = 16'hB861; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mvn_loadb", mk(1,0,0, 3'd1,3'd0, 0,0,1,0,0,0,0, 2'b00,2'b00, 16'h0000));
    tick();
    chk("mvn_exec", mk(1,0,0, 3'd0,3'd0, 0,0,0,1,0,0,0, 2'b00,2'b11, 16'h0000));
    #2;
    reset_n = 1'b0;
    #1;
    chk("mvn_reset_async", ZERO);
    tick();
    chk("mvn_reset_held", ZERO);
    reset_n = 1'b1;
    tick();
    chk("mvn_post_reset_idle", ZERO);
    tick();
    chk("mvn_no_write", ZERO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
